// File: rtl/sec_ones_tick_pkg.sv
// rtl/sec_ones_tick_pkg.sv - shared clock package: FSM states and BCD limits
// Used by the seconds-ones stage and its siblings in the clock chain.
package sec_ones_tick_pkg;

  typedef enum logic [1:0] {
    STOPPED = 2'd0,
    RUNNING = 2'd1,
    SETTING = 2'd2
  } sec_state_t;

  localparam logic [3:0] BCD_MAX_ONES = 4'd9;

  // Next BCD ones value; anything at or above the max folds back to zero.
  function automatic logic [3:0] bcd_ones_next(input logic [3:0] cur);
    return (cur >= BCD_MAX_ONES) ? 4'd0 : cur + 4'd1;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// rtl/tick_prescaler.sv - free-running 0..DIV-1 timebase with hold and clear
// tick is combinational: it marks the edge on which the count wraps to zero.
module tick_prescaler #(
  parameter int DIV = 50_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] CNT_MAX = W'(DIV - 1);

  logic [W-1:0] cnt;

  assign tick = en && (cnt == CNT_MAX);

  // clr outranks en; with en low the count simply holds, keeping phase.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + W'(1);
    end
  end

endmodule

// File: rtl/sec_ones_tick.sv
// rtl/sec_ones_tick.sv - seconds-ones BCD digit with run/pause/set FSM
// Generates registered tick, tens-carry and minute-carry pulses.
module sec_ones_tick
  import sec_ones_tick_pkg::*;
#(
  parameter int DIV = 50_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic       set,
  input  logic [3:0] new_val,
  input  logic       tens_hit5,
  output logic [3:0] Q,
  output logic       inc_tens,
  output logic       min_inc,
  output logic       tick,
  output logic       running
);

  sec_state_t state;
  sec_state_t state_nxt;

  logic pre_en;
  logic pre_clr;
  logic pre_tick;
  logic ones_wrap;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= STOPPED;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (set) begin
      state_nxt = SETTING;
    end else begin
      case (state)
        SETTING: state_nxt = run ? RUNNING : STOPPED;
        STOPPED: if (run) state_nxt = RUNNING;
        RUNNING: if (!run) state_nxt = STOPPED;
        default: state_nxt = STOPPED;
      endcase
    end
  end

  // Gating on run and set lets a falling run or rising set veto a pending tick.
  assign pre_en  = (state == RUNNING) && run && !set;
  assign pre_clr = (state == SETTING);

  tick_prescaler #(
    .DIV (DIV)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .en    (pre_en),
    .clr   (pre_clr),
    .tick  (pre_tick)
  );

  assign ones_wrap = pre_tick && (Q == BCD_MAX_ONES);
  assign running   = (state == RUNNING);

  // Out-of-range set values are ignored so Q stays a legal BCD digit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      Q <= 4'd0;
    end else if (set) begin
      if (new_val <= BCD_MAX_ONES) begin
        Q <= new_val;
      end
    end else if (pre_tick) begin
      Q <= bcd_ones_next(Q);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick     <= 1'b0;
      inc_tens <= 1'b0;
      min_inc  <= 1'b0;
    end else begin
      tick     <= pre_tick;
      inc_tens <= ones_wrap;
      min_inc  <= ones_wrap && tens_hit5;
    end
  end

endmodule
